// File: rtl/time_display_mux_pkg.sv
// Shared constants for the six-digit time display: segment patterns
// ({g,f,e,d,c,b,a}, active-low) and the scan digit index encoding.
package time_display_mux_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [2:0] {
    DIG_SEC_ONES = 3'd0,
    DIG_SEC_TENS = 3'd1,
    DIG_MIN_ONES = 3'd2,
    DIG_MIN_TENS = 3'd3,
    DIG_HRS_ONES = 3'd4,
    DIG_HRS_TENS = 3'd5
  } digit_e;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d < 4'd10) ? SEG_TABLE[d] : SEG_DASH;
  endfunction

endpackage

// File: rtl/time_display_mux_bin2bcd_2d.sv
// Combinational binary (0..99) to two-digit BCD converter.
module bin2bcd_2d (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  always_comb begin
    tens = 4'(bin / 7'd10);
    ones = 4'(bin % 7'd10);
  end

endmodule

// File: rtl/time_display_mux.sv
// Six-digit multiplexed 7-segment driver for sec/min/hrs with per-frame snapshot.
// Optional TWELVE_HOUR_EN: 12-hour hours display with PM indicator on digit-0 dp.
module time_display_mux
  import time_display_mux_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk_1kHz,
  input  logic       reset,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hrs,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp
);

  logic [15:0] div_q, div_d;
  digit_e      idx_q, idx_d;
  logic [5:0]  snap_sec, snap_min;
  logic [4:0]  snap_hrs;
  logic        frame_start;
  logic [5:0]  src_sec, src_min;
  logic [4:0]  src_hrs, hrs_disp;
  logic        pm;
  logic [3:0]  sec_t, sec_o, min_t, min_o, hrs_t, hrs_o;
  logic        sec_bad, min_bad, hrs_bad;
  logic [6:0]  seg_d;
  logic [5:0]  an_d;
  logic        dp_d;

  // The snapshot cycle decodes the live inputs so digit 0 already shows the new frame.
  always_comb begin
    frame_start = (div_q == '0) && (idx_q == DIG_SEC_ONES);
    src_sec = frame_start ? sec : snap_sec;
    src_min = frame_start ? min : snap_min;
    src_hrs = frame_start ? hrs : snap_hrs;
    sec_bad = src_sec > 6'd59;
    min_bad = src_min > 6'd59;
    hrs_bad = src_hrs > 5'd23;
  end

`ifdef TWELVE_HOUR_EN
  always_comb begin
    pm = src_hrs >= 5'd12;
    if (src_hrs == '0)
      hrs_disp = 5'd12;
    else if (src_hrs > 5'd12)
      hrs_disp = src_hrs - 5'd12;
    else
      hrs_disp = src_hrs;
  end
`else
  always_comb begin
    pm       = 1'b0;
    hrs_disp = src_hrs;
  end
`endif

  bin2bcd_2d u_sec (.bin({1'b0, src_sec}),  .tens(sec_t), .ones(sec_o));
  bin2bcd_2d u_min (.bin({1'b0, src_min}),  .tens(min_t), .ones(min_o));
  bin2bcd_2d u_hrs (.bin({2'b0, hrs_disp}), .tens(hrs_t), .ones(hrs_o));

  always_ff @(posedge clk_1kHz) begin
    if (reset) begin
      div_q    <= '0;
      idx_q    <= DIG_SEC_ONES;
      snap_sec <= '0;
      snap_min <= '0;
      snap_hrs <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      if (frame_start) begin
        snap_sec <= sec;
        snap_min <= min;
        snap_hrs <= hrs;
      end
    end
  end

  always_comb begin
    div_d = div_q + 16'd1;
    idx_d = idx_q;
    if (div_q == 16'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == DIG_HRS_TENS) ? DIG_SEC_ONES : digit_e'(idx_q + 3'd1);
    end
  end

  always_comb begin
    an_d  = ~(6'd1 << idx_q);
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    case (idx_q)
      DIG_SEC_ONES: begin
        seg_d = sec_bad ? SEG_DASH : seg_of(sec_o);
        dp_d  = ~pm;
      end
      DIG_SEC_TENS: seg_d = sec_bad ? SEG_DASH : seg_of(sec_t);
      DIG_MIN_ONES: begin
        seg_d = min_bad ? SEG_DASH : seg_of(min_o);
        dp_d  = src_sec[0];
      end
      DIG_MIN_TENS: seg_d = min_bad ? SEG_DASH : seg_of(min_t);
      DIG_HRS_ONES: begin
        seg_d = hrs_bad ? SEG_DASH : seg_of(hrs_o);
        dp_d  = src_sec[0];
      end
      DIG_HRS_TENS: seg_d = hrs_bad ? SEG_DASH : (hrs_t == '0) ? SEG_BLANK : seg_of(hrs_t);
      default: an_d = '1;
    endcase
  end

  always_ff @(posedge clk_1kHz) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
